// File: rtl/regfile_driver.sv
`default_nettype none
// ============================================================================
// Module   : regfile_driver
// Brief    : Multi-cycle register-to-register command engine driving a
//            32-entry register file (read ports 1/2 and the write port).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_driver #(
   parameter int DATAWIDTH = 32,
   parameter int ZERO_REG  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [4:0]           cmd_rd,
   input  logic [4:0]           cmd_rs1,
   input  logic [4:0]           cmd_rs2,
   input  logic [DATAWIDTH-1:0] cmd_imm,
   output logic [4:0]           readReg1,
   output logic [4:0]           readReg2,
   input  logic [DATAWIDTH-1:0] readData1,
   input  logic [DATAWIDTH-1:0] readData2,
   output logic [4:0]           writeReg,
   output logic [DATAWIDTH-1:0] writeData,
   output logic                 write,
   output logic                 done,
   output logic [DATAWIDTH-1:0] result
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_EXEC  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   localparam logic [1:0] c_OP_ADD = 2'b00;
   localparam logic [1:0] c_OP_SUB = 2'b01;
   localparam logic [1:0] c_OP_AND = 2'b10;

   state_t                 r_state;
   state_t                 w_next;
   logic                   w_ready;
   logic                   w_write;
   logic                   w_done;
   logic [DATAWIDTH-1:0]   w_alu;

   logic [1:0]             r_op;
   logic [4:0]             r_rd;
   logic [DATAWIDTH-1:0]   r_imm;
   logic [DATAWIDTH-1:0]   r_op_a;
   logic [DATAWIDTH-1:0]   r_op_b;
   logic [4:0]             r_read_reg1;
   logic [4:0]             r_read_reg2;
   logic [4:0]             r_write_reg;
   logic [DATAWIDTH-1:0]   r_result;

   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      w_write = 1'b0;
      w_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (cmd_valid) w_next = S_READ;
         end
         S_READ:  w_next = S_EXEC;
         S_EXEC:  w_next = S_WRITE;
         S_WRITE: begin
            w_ready = 1'b1;
            w_done  = 1'b1;
            w_write = !((ZERO_REG != 0) && (r_rd == 5'd0));
            w_next  = cmd_valid ? S_READ : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_alu = r_imm;
      case (r_op)
         c_OP_ADD: w_alu = r_op_a + r_op_b;
         c_OP_SUB: w_alu = r_op_a - r_op_b;
         c_OP_AND: w_alu = r_op_a & r_op_b;
         default:  w_alu = r_imm;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_op        <= 2'b00;
         r_rd        <= 5'd0;
         r_imm       <= '0;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_read_reg1 <= 5'd0;
         r_read_reg2 <= 5'd0;
         r_write_reg <= 5'd0;
         r_result    <= '0;
      end else begin
         r_state <= w_next;
         // Read addresses are registered at accept so they are valid throughout READ
         if (w_ready && cmd_valid) begin
            r_op        <= cmd_op;
            r_rd        <= cmd_rd;
            r_imm       <= cmd_imm;
            r_read_reg1 <= cmd_rs1;
            r_read_reg2 <= cmd_rs2;
         end
         if (r_state == S_READ) begin
            r_op_a <= readData1;
            r_op_b <= readData2;
         end
         if (r_state == S_EXEC) begin
            r_result    <= w_alu;
            r_write_reg <= r_rd;
         end
      end
   end

   // Gating with reset keeps a mid-command reset from leaking a write pulse
   assign cmd_ready = w_ready & ~reset;
   assign write     = w_write & ~reset;
   assign done      = w_done & ~reset;
   assign readReg1  = r_read_reg1;
   assign readReg2  = r_read_reg2;
   assign writeReg  = r_write_reg;
   assign writeData = r_result;
   assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_regfile_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_driver
// Brief    : Randomized self-checking bench for regfile_driver with a
//            command-level reference model and a behavioural register file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_driver;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [4:0]    cmd_rd, cmd_rs1, cmd_rs2;
   logic [DW-1:0] cmd_imm;
   logic [4:0]    readReg1, readReg2, writeReg;
   logic [DW-1:0] readData1, readData2, writeData, result;
   logic          write, done;

   logic [DW-1:0] rf  [32];
   logic [DW-1:0] mdl [32];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   regfile_driver #(.DATAWIDTH(DW), .ZERO_REG(1)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
      .cmd_imm(cmd_imm),
      .readReg1(readReg1), .readReg2(readReg2),
      .readData1(readData1), .readData2(readData2),
      .writeReg(writeReg), .writeData(writeData), .write(write),
      .done(done), .result(result)
   );

   // Plain register file with no register-0 protection of its own
   always @(posedge clk) if (write) rf[writeReg] <= writeData;
   assign readData1 = rf[readReg1];
   assign readData2 = rf[readReg2];

   function automatic logic [DW-1:0] ref_op(input logic [1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [DW-1:0] imm);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return imm;
      endcase
   endfunction

   function automatic logic [DW-1:0] model_exec(input logic [1:0] op, input logic [4:0] rs1,
                                                input logic [4:0] rs2, input logic [DW-1:0] imm);
      return ref_op(op, mdl[rs1], mdl[rs2], imm);
   endfunction

   task automatic model_commit(input logic [4:0] rd, input logic [DW-1:0] v);
      if (rd != 5'd0) mdl[rd] = v;
   endtask

   // Drives one isolated command and reports what was seen in each phase
   task automatic do_cmd(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [DW-1:0] imm,
                         output bit acc, output logic [4:0] rr1, output logic [4:0] rr2,
                         output bit mid_bad, output bit wr, output bit dn, output bit wrdy,
                         output logic [4:0] wreg, output logic [DW-1:0] wdata, output bit post_bad);
      acc = 0; rr1 = 'x; rr2 = 'x; mid_bad = 1; wr = 0; dn = 0; wrdy = 0;
      wreg = 'x; wdata = 'x; post_bad = 1;
      cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
      cmd_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (cmd_ready) begin acc = 1; break; end
         @(posedge clk); #1;
      end
      if (!acc) begin cmd_valid = 1'b0; return; end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      rr1 = readReg1; rr2 = readReg2;
      mid_bad = cmd_ready | write | done;
      @(posedge clk); #1;
      mid_bad = mid_bad | cmd_ready | write | done;
      @(posedge clk); #1;
      wr = write; dn = done; wrdy = cmd_ready; wreg = writeReg; wdata = writeData;
      @(posedge clk); #1;
      post_bad = write | done;
   endtask

   bit            acc, mid_bad, wr, dn, wrdy, post_bad;
   logic [4:0]    rr1, rr2, wreg;
   logic [DW-1:0] wdata, exp_v;

   task automatic test_reset;
      reset = 1'b1; cmd_valid = 1'b0;
      cmd_op = 0; cmd_rd = 0; cmd_rs1 = 0; cmd_rs2 = 0; cmd_imm = 0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b exp 0", cmd_ready); end
      n_checks++; if (write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b exp 0", write); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", done); end
      n_checks++; if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h exp 0", result); end
      n_checks++; if ({readReg1, readReg2, writeReg} !== 15'd0) begin n_fail++; $display("FAIL reset_addr: got %h/%h/%h exp 0", readReg1, readReg2, writeReg); end
      n_checks++; if (writeData !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h exp 0", writeData); end
      reset = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b exp 1", cmd_ready); end
   endtask

   task automatic test_ldi;
      exp_v = model_exec(2'b11, 5'd0, 5'd0, 32'h0000_00AA);
      do_cmd(2'b11, 5'd5, 5'd0, 5'd0, 32'h0000_00AA, acc, rr1, rr2, mid_bad, wr, dn, wrdy, wreg, wdata, post_bad);
      model_commit(5'd5, exp_v);
      n_checks++; if (!acc) begin n_fail++; $display("FAIL ldi_accept: got timeout exp accept"); end
      n_checks++; if (mid_bad) begin n_fail++; $display("FAIL ldi_mid: got ready/write/done in READ/EXEC exp none"); end
      n_checks++; if ({wr, dn} !== 2'b11) begin n_fail++; $display("FAIL ldi_pulse: got write=%b done=%b exp 1/1", wr, dn); end
      n_checks++; if (wreg !== 5'd5) begin n_fail++; $display("FAIL ldi_wreg: got %0d exp 5", wreg); end
      n_checks++; if (wdata !== exp_v) begin n_fail++; $display("FAIL ldi_wdata: got %h exp %h", wdata, exp_v); end
      n_checks++; if (post_bad) begin n_fail++; $display("FAIL ldi_single_pulse: got pulse after WRITE exp none"); end
      n_checks++; if (result !== exp_v) begin n_fail++; $display("FAIL ldi_result: got %h exp %h", result, exp_v); end
   endtask

   task automatic test_wrap;
      do_cmd(2'b11, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, acc, rr1, rr2, mid_bad, wr, dn, wrdy, wreg, wdata, post_bad);
      model_commit(5'd1, 32'hFFFF_FFFF);
      do_cmd(2'b11, 5'd2, 5'd0, 5'd0, 32'h1, acc, rr1, rr2, mid_bad, wr, dn, wrdy, wreg, wdata, post_bad);
      model_commit(5'd2, 32'h1);
      exp_v = model_exec(2'b00, 5'd1, 5'd2, '0);
      do_cmd(2'b00, 5'd3, 5'd1, 5'd2, 32'h5555_5555, acc, rr1, rr2, mid_bad, wr, dn, wrdy, wreg, wdata, post_bad);
      model_commit(5'd3, exp_v);
      n_checks++; if (wdata !== exp_v || wr !== 1'b1) begin n_fail++; $display("FAIL add_wrap: got %h (write=%b) exp %h", wdata, wr, exp_v); end
      exp_v = model_exec(2'b01, 5'd2, 5'd1, '0);
      do_cmd(2'b01, 5'd4, 5'd2, 5'd1, 32'h0, acc, rr1, rr2, mid_bad, wr, dn, wrdy, wreg, wdata, post_bad);
      model_commit(5'd4, exp_v);
      n_checks++; if (wdata !== exp_v || wreg !== 5'd4) begin n_fail++; $display("FAIL sub_wrap: got %h@%0d exp %h@4", wdata, wreg, exp_v); end
      n_checks++; if (rf[4] !== mdl[4]) begin n_fail++; $display("FAIL sub_rf: got %h exp %h", rf[4], mdl[4]); end
   endtask

   task automatic test_back_to_back;
      int acc_cyc[$];
      int wr_cyc[$];
      logic [DW-1:0] wr_dat[$];
      bit pend = 0;
      logic [DW-1:0] exp1, exp2;
      exp1 = model_exec(2'b11, 5'd0, 5'd0, 32'd9);
      cmd_op = 2'b11; cmd_rd = 5'd7; cmd_rs1 = 5'd0; cmd_rs2 = 5'd0; cmd_imm = 32'd9;
      cmd_valid = 1'b1;
      for (int c = 0; c < 14; c++) begin
         if (pend) begin
            pend = 0;
            if (acc_cyc.size() == 1) begin
               cmd_op = 2'b00; cmd_rd = 5'd8; cmd_rs1 = 5'd7; cmd_rs2 = 5'd7; cmd_imm = 32'hDEAD_BEEF;
            end else cmd_valid = 1'b0;
         end
         if (write) begin wr_cyc.push_back(c); wr_dat.push_back(writeData); end
         if (cmd_valid && cmd_ready) begin acc_cyc.push_back(c); pend = 1; end
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      model_commit(5'd7, exp1);
      exp2 = model_exec(2'b00, 5'd7, 5'd7, '0);
      model_commit(5'd8, exp2);
      n_checks++;
      if (acc_cyc.size() != 2 || wr_cyc.size() != 2) begin
         n_fail++; $display("FAIL b2b_counts: got %0d accepts %0d writes exp 2/2", acc_cyc.size(), wr_cyc.size());
      end else begin
         n_checks++; if (wr_cyc[0] - acc_cyc[0] != 3) begin n_fail++; $display("FAIL b2b_latency: got %0d exp 3", wr_cyc[0] - acc_cyc[0]); end
         n_checks++; if (acc_cyc[1] != wr_cyc[0]) begin n_fail++; $display("FAIL b2b_accept_in_write: got cycle %0d exp %0d", acc_cyc[1], wr_cyc[0]); end
         n_checks++; if (wr_cyc[1] - wr_cyc[0] != 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d exp 3", wr_cyc[1] - wr_cyc[0]); end
         n_checks++; if (wr_dat[0] !== exp1) begin n_fail++; $display("FAIL b2b_wdata1: got %h exp %h", wr_dat[0], exp1); end
         n_checks++; if (wr_dat[1] !== exp2) begin n_fail++; $display("FAIL b2b_wdata2: got %h exp %h", wr_dat[1], exp2); end
      end
   endtask

   task automatic test_zero_reg;
      do_cmd(2'b11, 5'd0, 5'd0, 5'd0, 32'h1234, acc, rr1, rr2, mid_bad, wr, dn, wrdy, wreg, wdata, post_bad);
      n_checks++; if ({dn, wr} !== 2'b10) begin n_fail++; $display("FAIL zero_suppress: got done=%b write=%b exp 1/0", dn, wr); end
      n_checks++; if (rf[0] !== '0) begin n_fail++; $display("FAIL zero_rf: got %h exp 0", rf[0]); end
      exp_v = model_exec(2'b00, 5'd0, 5'd0, '0);
      do_cmd(2'b00, 5'd11, 5'd0, 5'd0, 32'h0, acc, rr1, rr2, mid_bad, wr, dn, wrdy, wreg, wdata, post_bad);
      model_commit(5'd11, exp_v);
      n_checks++; if (wdata !== exp_v) begin n_fail++; $display("FAIL zero_read: got %h exp %h", wdata, exp_v); end
   endtask

   task automatic test_reset_mid;
      bit saw_write = 0;
      bit got = 0;
      do_cmd(2'b11, 5'd6, 5'd0, 5'd0, 32'h0BAD_F00D, acc, rr1, rr2, mid_bad, wr, dn, wrdy, wreg, wdata, post_bad);
      model_commit(5'd6, 32'h0BAD_F00D);
      cmd_op = 2'b00; cmd_rd = 5'd6; cmd_rs1 = 5'd5; cmd_rs2 = 5'd5; cmd_imm = 0;
      cmd_valid = 1'b1;
      for (int i = 0; i < 8 && !got; i++) begin
         if (cmd_ready) got = 1;
         else begin @(posedge clk); #1; end
      end
      @(posedge clk); #1; cmd_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         saw_write = saw_write | write | done;
         @(posedge clk); #1;
      end
      n_checks++; if (!got || saw_write) begin n_fail++; $display("FAIL rst_mid_nowrite: got accept=%b pulse=%b exp 1/0", got, saw_write); end
      n_checks++; if ({result, writeData, writeReg, readReg1, readReg2} !== '0) begin n_fail++; $display("FAIL rst_mid_outputs: got res=%h wd=%h wr=%0d exp 0", result, writeData, writeReg); end
      reset = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b exp 1", cmd_ready); end
      n_checks++; if (rf[6] !== mdl[6]) begin n_fail++; $display("FAIL rst_mid_r6: got %h exp %h", rf[6], mdl[6]); end
   endtask

   task automatic test_and_same;
      do_cmd(2'b11, 5'd10, 5'd0, 5'd0, 32'hF0F0_F0F0, acc, rr1, rr2, mid_bad, wr, dn, wrdy, wreg, wdata, post_bad);
      model_commit(5'd10, 32'hF0F0_F0F0);
      exp_v = model_exec(2'b10, 5'd10, 5'd10, '0);
      do_cmd(2'b10, 5'd9, 5'd10, 5'd10, 32'h0, acc, rr1, rr2, mid_bad, wr, dn, wrdy, wreg, wdata, post_bad);
      model_commit(5'd9, exp_v);
      n_checks++; if (rr1 !== 5'd10 || rr2 !== 5'd10) begin n_fail++; $display("FAIL and_readaddr: got %0d/%0d exp 10/10", rr1, rr2); end
      n_checks++; if (wdata !== exp_v) begin n_fail++; $display("FAIL and_wdata: got %h exp %h", wdata, exp_v); end
   endtask

   task automatic test_random;
      logic [1:0]    op;
      logic [4:0]    rd, s1, s2;
      logic [DW-1:0] imm;
      for (int k = 0; k < 40; k++) begin
         op = 2'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 31));
         s1 = 5'($urandom_range(0, 31)); s2 = 5'($urandom_range(0, 31)); imm = $urandom;
         exp_v = model_exec(op, s1, s2, imm);
         do_cmd(op, rd, s1, s2, imm, acc, rr1, rr2, mid_bad, wr, dn, wrdy, wreg, wdata, post_bad);
         model_commit(rd, exp_v);
         n_checks++;
         if (!acc || mid_bad || post_bad || !dn || !wrdy || wr !== (rd != 5'd0) || wreg !== rd ||
             wdata !== exp_v || result !== exp_v || rr1 !== s1 || rr2 !== s2) begin
            n_fail++;
            $display("FAIL rand_%0d: got acc=%b wr=%b dn=%b rdy=%b reg=%0d data=%h res=%h rr=%0d/%0d exp wr=%b reg=%0d data=%h rr=%0d/%0d",
                     k, acc, wr, dn, wrdy, wreg, wdata, result, rr1, rr2, (rd != 5'd0), rd, exp_v, s1, s2);
         end
      end
      for (int r = 0; r < 32; r++) begin
         n_checks++; if (rf[r] !== mdl[r]) begin n_fail++; $display("FAIL rand_rf%0d: got %h exp %h", r, rf[r], mdl[r]); end
      end
   endtask

   initial begin
      for (int r = 0; r < 32; r++) begin rf[r] = '0; mdl[r] = '0; end
      test_reset();
      test_ldi();
      test_wrap();
      test_back_to_back();
      test_zero_reg();
      test_reset_mid();
      test_and_same();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
